cpu_qsys_sysid_reader: RTL and testbench

//   Avalon-MM read master for the system-ID slave. On start (or once after reset), reads word 0 (system ID), then word 1 (timestamp).

---
 rtl/cpu_qsys_sysid_reader.sv | 157 +++++++++++++++
 tb/tb_cpu_qsys_sysid_reader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_qsys_sysid_reader.sv
// cpu_qsys_sysid_reader: Avalon-MM read master that checks the sysid slave.
// It reads word 0 (system ID), then word 1 (timestamp), compares each with its
// expected value and holds a pass/fail/timeout verdict until the next start.
//
// Ports
//   clock_i              system clock
//   reset_ni             asynchronous active-low reset
//   start_i              begin a check (ignored while busy)
//   avm_address_o        word address (0 = ID, 1 = timestamp)
//   avm_read_o           read request, held until accepted
//   avm_waitrequest_i    slave stall
//   avm_readdata_i       read data
//   avm_readdatavalid_i  read data strobe
//   busy_o               check in progress
//   done_o               verdict valid
//   id_ok_o / ts_ok_o    captured words equal their expected values
//   timeout_err_o        a read did not complete within TIMEOUT_CYCLES
//   id_value_o           captured ID word
//   ts_value_o           captured timestamp word
module cpu_qsys_sysid_reader #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5A66_D431,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        start_i,
  output logic        avm_address_o,
  output logic        avm_read_o,
  input  logic        avm_waitrequest_i,
  input  logic [31:0] avm_readdata_i,
  input  logic        avm_readdatavalid_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        id_ok_o,
  output logic        ts_ok_o,
  output logic        timeout_err_o,
  output logic [31:0] id_value_o,
  output logic [31:0] ts_value_o
);

  typedef enum logic [2:0] {StIdle, StRdId, StWtId, StRdTs, StWtTs, StDone} state_e;

  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        auto_q, auto_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic        in_rd, in_wt, accept, capture, expired;
  logic [15:0] cnt_inc;

  always_comb begin
    in_rd   = (state_q == StRdId) || (state_q == StRdTs);
    in_wt   = (state_q == StWtId) || (state_q == StWtTs);
    accept  = in_rd && !avm_waitrequest_i;
    // Responses are only taken while a read of ours is in flight; strays are dropped.
    capture = (accept || in_wt) && avm_readdatavalid_i;
    cnt_inc = cnt_q + 16'd1;
    expired = (in_rd || in_wt) && (cnt_inc >= TimeoutLimit);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    auto_d     = auto_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;

    if (in_rd || in_wt) cnt_d = cnt_inc;

    case (state_q)
      StIdle, StDone: begin
        if (start_i || (auto_q && state_q == StIdle)) begin
          state_d    = StRdId;
          cnt_d      = '0;
          auto_d     = 1'b0;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          timeout_d  = 1'b0;
          id_value_d = '0;
          ts_value_d = '0;
        end
      end
      StRdId, StWtId: begin
        // Capture has priority over a timeout expiring in the same cycle.
        if (capture) begin
          id_value_d = avm_readdata_i;
          id_ok_d    = (avm_readdata_i == EXPECTED_ID);
          state_d    = StRdTs;
          cnt_d      = '0;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else if (accept) begin
          state_d = StWtId;
        end
      end
      StRdTs, StWtTs: begin
        if (capture) begin
          ts_value_d = avm_readdata_i;
          ts_ok_d    = (avm_readdata_i == EXPECTED_TIMESTAMP);
          state_d    = StDone;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else if (accept) begin
          state_d = StWtTs;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      auto_q     <= AUTO_START;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      auto_q     <= auto_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  // Bus controls decode straight from state so an async reset drops the read at once.
  assign avm_read_o    = in_rd;
  assign avm_address_o = (state_q == StRdTs);
  assign busy_o        = in_rd || in_wt;
  assign done_o        = (state_q == StDone);
  assign id_ok_o       = id_ok_q;
  assign ts_ok_o       = ts_ok_q;
  assign timeout_err_o = timeout_q;
  assign id_value_o    = id_value_q;
  assign ts_value_o    = ts_value_q;

endmodule

// File: tb/tb_cpu_qsys_sysid_reader.sv
module tb_cpu_qsys_sysid_reader;

  localparam int unsigned ToCycles = 8;
  localparam logic [31:0] ExpTs    = 32'h5A66_D431;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        addr, rd, wreq, rdv;
  logic [31:0] rdata;
  logic        busy, done, id_ok, ts_ok, to_err;
  logic [31:0] id_val, ts_val;

  always #5 clk = ~clk;

  cpu_qsys_sysid_reader #(
    .EXPECTED_ID       (32'h0000_0000),
    .EXPECTED_TIMESTAMP(ExpTs),
    .TIMEOUT_CYCLES    (ToCycles),
    .AUTO_START        (1'b1)
  ) dut (
    .clock_i            (clk),
    .reset_ni           (rst_n),
    .start_i            (start),
    .avm_address_o      (addr),
    .avm_read_o         (rd),
    .avm_waitrequest_i  (wreq),
    .avm_readdata_i     (rdata),
    .avm_readdatavalid_i(rdv),
    .busy_o             (busy),
    .done_o             (done),
    .id_ok_o            (id_ok),
    .ts_ok_o            (ts_ok),
    .timeout_err_o      (to_err),
    .id_value_o         (id_val),
    .ts_value_o         (ts_val)
  );

  // Slave model configuration (written only by the stimulus process).
  logic [31:0] id_w = 32'h0;
  logic [31:0] ts_w = ExpTs;
  int          stall_cfg = 0;
  int          lat_cfg = 0;
  bit          stuck = 1'b0;
  bit          stray = 1'b0;

  // Slave model state.
  int          stall_cnt;
  int          pend_cnt;
  bit          pend_v;
  logic [31:0] pend_data;

  always_comb begin
    wreq = rd && (stuck || (stall_cnt < stall_cfg));
    if (lat_cfg == 0) begin
      rdv   = rd && !wreq;
      rdata = addr ? ts_w : id_w;
    end else begin
      rdv   = pend_v && (pend_cnt == 0);
      rdata = pend_data;
    end
    if (stray) begin
      rdv   = 1'b1;
      rdata = 32'hDEAD_BEEF;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 0;
      pend_cnt  <= 0;
      pend_v    <= 1'b0;
      pend_data <= '0;
    end else begin
      if (pend_v) begin
        if (pend_cnt == 0) pend_v <= 1'b0;
        else pend_cnt <= pend_cnt - 1;
      end
      if (!rd) begin
        stall_cnt <= 0;
      end else if (wreq) begin
        stall_cnt <= stall_cnt + 1;
      end else begin
        stall_cnt <= 0;
        if (lat_cfg > 0) begin
          pend_v    <= 1'b1;
          pend_cnt  <= lat_cfg - 1;
          pend_data <= addr ? ts_w : id_w;
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Address and read must hold while the slave stalls.
  logic prev_stall = 1'b0;
  logic prev_addr = 1'b0;
  always @(negedge clk) begin
    if (prev_stall && rst_n && busy) begin
      chk("stall_addr_stable", {31'b0, addr}, {31'b0, prev_addr});
      chk("stall_read_held", {31'b0, rd}, 32'd1);
    end
    prev_stall <= rd && wreq && rst_n;
    prev_addr  <= addr;
  end

  typedef struct {
    logic [31:0] id_word;
    logic [31:0] ts_word;
    int          stall;
    int          lat;
    bit          stuck;
    bit          exp_id_ok;
    bit          exp_ts_ok;
    bit          exp_to;
  } vec_t;

  typedef struct {
    bit          id_ok;
    bit          ts_ok;
    bit          to;
    logic [31:0] idv;
    logic [31:0] tsv;
    int          busy_n;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  function automatic exp_t model(input vec_t v);
    exp_t e;
    e.id_ok = v.exp_id_ok;
    e.ts_ok = v.exp_ts_ok;
    e.to    = v.exp_to;
    if (v.stuck) begin
      e.idv    = '0;
      e.tsv    = '0;
      e.busy_n = int'(ToCycles);
    end else begin
      e.idv    = v.id_word;
      e.tsv    = v.ts_word;
      e.busy_n = 2 * (v.stall + 1 + v.lat);
    end
    return e;
  endfunction

  task automatic configure(input vec_t v);
    id_w      = v.id_word;
    ts_w      = v.ts_word;
    stall_cfg = v.stall;
    lat_cfg   = v.lat;
    stuck     = v.stuck;
  endtask

  // Waits (bounded) for done, counting busy cycles; optionally toggles start meanwhile.
  task automatic wait_done(input bit poke, output int busy_n);
    int n = 0;
    busy_n = 0;
    while (!done && n < 200) begin
      if (busy) busy_n++;
      if (poke) start = ~start;
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_done: done=0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic compare_verdict(input string tag, input int busy_n);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: got empty queue, expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_id_ok"}, {31'b0, id_ok}, {31'b0, e.id_ok});
    chk({tag, "_ts_ok"}, {31'b0, ts_ok}, {31'b0, e.ts_ok});
    chk({tag, "_timeout"}, {31'b0, to_err}, {31'b0, e.to});
    chk({tag, "_id_value"}, id_val, e.idv);
    chk({tag, "_ts_value"}, ts_val, e.tsv);
    chk({tag, "_busy_cycles"}, busy_n, e.busy_n);
    chk({tag, "_read_idle"}, {31'b0, rd}, 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v, input bit poke);
    int b;
    configure(v);
    sb.push_back(model(v));
    pulse_start();
    chk({tag, "_start_busy"}, {31'b0, busy}, 32'd1);
    wait_done(poke, b);
    compare_verdict(tag, b);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_read"}, {31'b0, rd}, 32'd0);
    chk({tag, "_addr"}, {31'b0, addr}, 32'd0);
    chk({tag, "_flags"}, {29'b0, id_ok, ts_ok, to_err}, 32'd0);
    chk({tag, "_id_value"}, id_val, 32'd0);
    chk({tag, "_ts_value"}, ts_val, 32'd0);
  endtask

  initial begin
    int   b;
    vec_t pass;

    //           id_word         ts_word        stall lat stuck id ts to
    vecs[0] = '{32'h0000_0000, ExpTs,          0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h5A66_D430,  0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0001, ExpTs,          0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0000, ExpTs,          4, 2, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000,  2, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0000, ExpTs,          5, 2, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'h1234_5678, ExpTs,          0, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{32'h0000_0000, ExpTs,          0, 3, 1'b0, 1'b1, 1'b1, 1'b0};
    pass = vecs[0];

    // Reset state, then the automatic check after release.
    #2;
    chk_all_zero("reset");
    configure(pass);
    sb.push_back(model(pass));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_done(1'b0, b);
    compare_verdict("auto", b);

    // Latency: RD_ID, RD_TS, then done; a start landing on the DONE entry edge is ignored.
    pulse_start();
    chk("lat_rd_id", {30'b0, busy, rd}, 32'd3);
    chk("lat_rd_id_addr", {31'b0, addr}, 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("lat_rd_ts", {30'b0, rd, addr}, 32'd3);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("lat_done", {30'b0, done, busy}, 32'd2);
    @(posedge clk);
    #1;
    chk("coincident_start_ignored", {30'b0, done, busy}, 32'd2);

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i], 1'b0);

    // Starts while busy are ignored; stray response in DONE leaves the verdict alone.
    run_vec("busy_start", vecs[3], 1'b1);
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(posedge clk);
    #1;
    chk("stray_state", {30'b0, done, busy}, 32'd2);
    chk("stray_id_value", id_val, 32'h0000_0000);
    chk("stray_ts_value", ts_val, ExpTs);
    chk("stray_flags", {29'b0, id_ok, ts_ok, to_err}, 32'd6);

    // Reset while waiting for the ID response, then the automatic rerun.
    pass.lat = 3;
    configure(pass);
    pulse_start();
    @(posedge clk);
    #1;
    chk("wt_id_state", {30'b0, busy, rd}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    pass.lat = 0;
    configure(pass);
    sb.push_back(model(pass));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_done(1'b0, b);
    compare_verdict("rerun", b);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
